// File: rtl/pulse_meter_pkg.sv
// Shared constants for the pulse meter: FSM state encoding and default widths.
package pulse_meter_pkg;

  localparam int CNT_W_DEF    = 16;
  localparam int FILT_LEN_DEF = 4;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_RISE = 2'd1;
  localparam logic [1:0] ST_MEAS_HI   = 2'd2;
  localparam logic [1:0] ST_MEAS_LO   = 2'd3;

endpackage

// File: rtl/pulse_meter_cond.sv
// sig_conditioner: 2-FF synchroniser, registered level, rise/fall detect.
// Define MEAS_FILTER_EN to add a FILT_LEN-cycle stability filter in place of the level register.
module sig_conditioner
  import pulse_meter_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("sig_conditioner: FILT_LEN must be at least 1");
  end

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic lvl_q, lvl_d;
  logic lvl_dly_q, lvl_dly_d;

`ifdef MEAS_FILTER_EN
  localparam int RUN_W = $clog2(FILT_LEN + 1);
  logic [RUN_W-1:0] run_q, run_d;
`endif

  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    sync1_d   = sig_in;
    sync2_d   = sync1_q;
    lvl_dly_d = lvl_q;
`ifdef MEAS_FILTER_EN
    lvl_d = lvl_q;
    run_d = '0;
    // Flip only after FILT_LEN consecutive disagreeing samples; any agreement restarts the run.
    if (sync2_q != lvl_q) begin
      if (run_q == RUN_W'(FILT_LEN - 1)) begin
        lvl_d = sync2_q;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
`else
    lvl_d = sync2_q;
`endif
  end

  // NOTE: the reset is synchronous and active-high; it is just the highest-priority branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values of its neighbours.
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_dly_d;
    end
  end

`ifdef MEAS_FILTER_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end
`endif

  assign lvl  = lvl_q;
  assign rise = lvl_q & ~lvl_dly_q;
  assign fall = ~lvl_q & lvl_dly_q;

endmodule

// File: rtl/pulse_meter.sv
// pulse_meter: measures high time, low time and period of an asynchronous periodic input.
// Optional glitch filter in the conditioner is enabled by defining MEAS_FILTER_EN.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             level,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic lvl, rise, fall;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  sig_conditioner #(
    .FILT_LEN (FILT_LEN)
  ) u_cond (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .lvl    (lvl),
    .rise   (rise),
    .fall   (fall)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_lat_d  = hi_lat_q;
    high_d    = high_q;
    low_d     = low_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    // IDLE waits for a fall so a phase already running at arm time is never measured.
    case (state_q)
      ST_IDLE: begin
        if (fall) state_d = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (rise) begin
          state_d = ST_MEAS_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_MEAS_HI: begin
        if (fall) begin
          hi_lat_d = cnt_q;
          cnt_d    = CNT_W'(1);
          state_d  = ST_MEAS_LO;
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_MEAS_LO: begin
        if (rise) begin
          high_d   = hi_lat_q;
          low_d    = cnt_q;
          period_d = {1'b0, hi_lat_q} + {1'b0, cnt_q};
          valid_d  = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = ST_MEAS_HI;
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_lat_q  <= '0;
      high_q    <= '0;
      low_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_lat_q  <= hi_lat_d;
      high_q    <= high_d;
      low_q     <= low_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign level      = lvl;
  assign high_time  = high_q;
  assign low_time   = low_q;
  assign period     = period_q;
  assign meas_valid = valid_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Self-checking bench for pulse_meter (CNT_W=4) against a run-length model of the input waveform.
module tb_pulse_meter;

  localparam int CNT_W = 4;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sig_in = 1'b0;
  logic             level;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] low_time;
  logic [CNT_W:0]   period;
  logic             meas_valid;
  logic             timeout;

  always #5 clk = ~clk;

  pulse_meter #(
    .CNT_W    (CNT_W),
    .FILT_LEN (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .level      (level),
    .high_time  (high_time),
    .low_time   (low_time),
    .period     (period),
    .meas_valid (meas_valid),
    .timeout    (timeout)
  );

  typedef struct {
    bit valid;
    bit tout;
    int hi;
    int lo;
    int per;
  } exp_t;

  exp_t exp_q[$];
  bit   lvl_q[$];

  // Model: the conditioned level is the input stream itself, seen through a fixed pipeline.
  bit   m_prev;
  int   m_run;
  bit   m_armed;   // a fall has been seen since reset/timeout
  bit   m_meas;    // current run belongs to a measurement
  int   m_hi;
  exp_t m_out;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_tout   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_t z;
    z = '{valid: 1'b0, tout: 1'b0, hi: 0, lo: 0, per: 0};
    exp_q.delete();
    lvl_q.delete();
    repeat (3) exp_q.push_back(z);
    repeat (2) lvl_q.push_back(1'b0);
    m_prev  = 1'b0;
    m_run   = 1;
    m_armed = 1'b0;
    m_meas  = 1'b0;
    m_hi    = 0;
    m_out   = z;
  endfunction

  function automatic void model_step(input bit l);
    exp_t o;
    o       = m_out;
    o.valid = 1'b0;
    o.tout  = 1'b0;
    if (l != m_prev) begin
      if (!l) begin
        if (m_meas) m_hi = m_run;
        m_armed = 1'b1;
      end else begin
        if (m_meas) begin
          o.valid = 1'b1;
          o.hi    = m_hi;
          o.lo    = m_run;
          o.per   = m_hi + m_run;
        end
        m_meas = m_armed;
      end
      m_run = 1;
    end else begin
      m_run++;
      if (m_meas && m_run == MAXV + 1) begin
        o.tout  = 1'b1;
        m_meas  = 1'b0;
        m_armed = 1'b0;
      end
    end
    m_prev = l;
    m_out  = o;
    exp_q.push_back(o);
    lvl_q.push_back(l);
  endfunction

  task automatic step(input bit v);
    exp_t e;
    bit   el;
    sig_in = v;
    @(posedge clk);
    model_step(v);
    e  = exp_q.pop_front();
    el = lvl_q.pop_front();
    @(negedge clk);
    check("meas_valid", meas_valid, e.valid);
    check("timeout", timeout, e.tout);
    check("high_time", high_time, e.hi);
    check("low_time", low_time, e.lo);
    check("period", period, e.per);
    check("level", level, el);
    check("strobe_exclusive", meas_valid & timeout, 0);
    if (meas_valid === 1'b1) n_valid++;
    if (timeout === 1'b1) n_tout++;
  endtask

  task automatic run(input bit v, input int n);
    repeat (n) step(v);
  endtask

  task automatic do_reset(input bit v);
    sig_in = v;
    rst    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_high_time", high_time, 0);
    check("rst_low_time", low_time, 0);
    check("rst_period", period, 0);
    check("rst_level", level, 0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, t0;
    bit v;

    // 3 high / 4 low from a low start: first rise ignored, reports from the third rise on.
    do_reset(1'b0);
    v0 = n_valid; t0 = n_tout;
    run(1'b0, 4);
    repeat (5) begin
      run(1'b1, 3);
      run(1'b0, 4);
    end
    run(1'b1, 4);
    check("t1_valid_count", n_valid - v0, 4);
    check("t1_timeout_count", n_tout - t0, 0);
    check("t1_high_time", high_time, 3);
    check("t1_low_time", low_time, 4);
    check("t1_period", period, 7);

    // High through reset release, then 5/5: the first report is 5/5/10.
    do_reset(1'b1);
    v0 = n_valid;
    run(1'b1, 5); run(1'b0, 5); run(1'b1, 5); run(1'b0, 5); run(1'b1, 5);
    check("t2_valid_count", n_valid - v0, 1);
    check("t2_high_time", high_time, 5);
    check("t2_low_time", low_time, 5);
    check("t2_period", period, 10);

    // Stuck high in MEAS_HI: one timeout, values kept, then fall+rise+fall+rise needed.
    v0 = n_valid; t0 = n_tout;
    run(1'b1, 20);
    check("t3_timeout_count", n_tout - t0, 1);
    check("t3_valid_count", n_valid - v0, 0);
    check("t3_high_kept", high_time, 5);
    run(1'b0, 3); run(1'b1, 3); run(1'b0, 3);
    check("t3_no_early_valid", n_valid - v0, 0);
    run(1'b1, 4);
    check("t3_rearm_valid", n_valid - v0, 1);
    check("t3_period", period, 6);

    // High exactly MAX: the edge wins and 15/2/17 is published without timeout.
    v0 = n_valid; t0 = n_tout;
    run(1'b0, 2); run(1'b1, 15); run(1'b0, 2); run(1'b1, 4);
    check("t4_valid_count", n_valid - v0, 2);
    check("t4_timeout_count", n_tout - t0, 0);
    check("t4_high_time", high_time, 15);
    check("t4_low_time", low_time, 2);
    check("t4_period", period, 17);

    // Reset mid low phase: outputs clear, no stale strobe afterwards.
    run(1'b0, 6);
    do_reset(1'b0);
    v0 = n_valid; t0 = n_tout;
    run(1'b1, 4); run(1'b0, 4);
    check("t5_valid_count", n_valid - v0, 0);
    check("t5_timeout_count", n_tout - t0, 0);

    // 2-cycle glitch inside a 10-cycle high: unfiltered build reports split phases.
    do_reset(1'b0);
    v0 = n_valid;
    run(1'b0, 3); run(1'b1, 3); run(1'b0, 3);
    run(1'b1, 4); run(1'b0, 2); run(1'b1, 4); run(1'b0, 10); run(1'b1, 4);
    check("t6_valid_count", n_valid - v0, 2);
    check("t6_high_time", high_time, 4);
    check("t6_low_time", low_time, 10);
    check("t6_period", period, 14);

    // Random run lengths, some beyond MAX, with occasional resets.
    v = 1'b0;
    repeat (250) begin
      if ($urandom_range(0, 39) == 0) do_reset(1'($urandom_range(0, 1)));
      v = ~v;
      run(v, int'($urandom_range(1, 20)));
    end
    run(v, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
